// File: rtl/spr_pkg.sv
// Shared constants for the SPR edge-prep path: default geometry and o_is_edge bit positions.
package spr_pkg;

   localparam int SPR_DW    = 12;
   localparam int SPR_MAX_W = 1920;

   localparam int EDGE_L  = 3;
   localparam int EDGE_R  = 2;
   localparam int EDGE_U  = 1;
   localparam int EDGE_UL = 0;

endpackage

// File: rtl/spr_line_buf.sv
// One-line pixel buffer: single clock, read-first, synchronous read (1-cycle latency).
// Contents are never reset so the array maps onto block RAM.
module spr_line_buf
   import spr_pkg::*;
#(
   parameter int DW    = SPR_DW,
   parameter int DEPTH = SPR_MAX_W,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdat_i,
   output logic [DW-1:0] rdat_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdat_q;

   // Every access is a read of the old word plus a write of the new one.
   always_ff @(posedge clk) begin
      if (en_i) begin
         rdat_q         <= mem_q[addr_i];
         mem_q[addr_i]  <= wdat_i;
      end
   end

   assign rdat_o = rdat_q;

endmodule

// File: rtl/spr_edge_prep.sv
// Builds the left/centre/right/up/up-left window for one colour channel and classifies edges
// against i_th; outputs are registered so they line up with i_hs/i_vs delayed two cycles.
module spr_edge_prep
   import spr_pkg::*;
#(
   parameter int DW    = SPR_DW,
   parameter int MAX_W = SPR_MAX_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_hs,
   input  logic          i_vs,
   input  logic [DW-1:0] i_pix,
   input  logic [DW-1:0] i_th,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_en,
   output logic [DW-1:0] o_prev,
   output logic [DW-1:0] o_curr,
   output logic [3:0]    o_is_edge
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int CW = $clog2(MAX_W + 1);

   logic          v;
   logic          in_rng;
   logic          buf_en;
   logic          emit;
   logic          up_ok;
   logic [DW-1:0] up_rd;
   logic [DW-1:0] ul;
   logic [3:0]    edge_d;

   logic [CW-1:0] x_cnt_q;
   logic [DW-1:0] c_q;
   logic [DW-1:0] l_q;
   logic [DW-1:0] ul_q;
   logic          c_vld_q;
   logic          c_first_q;
   logic          c_big_q;
   logic          row_seen_q;
   logic [1:0]    hs_q;
   logic [1:0]    vs_q;
   logic          en_q;
   logic [DW-1:0] prev_q;
   logic [DW-1:0] curr_q;
   logic [3:0]    edge_q;

   function automatic logic abs_gt(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] th);
      logic signed [DW:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d < 0) d = -d;
      return d > $signed({1'b0, th});
   endfunction

   assign v      = i_hs & i_vs;
   assign in_rng = (x_cnt_q < CW'(MAX_W));
   assign buf_en = v & in_rng;

   spr_line_buf #(
      .DW    (DW),
      .DEPTH (MAX_W),
      .AW    (AW)
   ) u_line_buf (
      .clk    (clk),
      .en_i   (buf_en),
      .addr_i (x_cnt_q[AW-1:0]),
      .wdat_i (i_pix),
      .rdat_o (up_rd)
   );

   // row_seen_q is the inverse of row_first, so the line buffer is ignored straight out of reset.
   assign up_ok = row_seen_q & ~c_big_q;
   assign ul    = c_first_q ? up_rd : ul_q;
   assign emit  = c_vld_q & i_vs;

   // With v low this is the flush cycle: right collapses onto the centre, so [R] is simply 0.
   always_comb begin
      edge_d          = '0;
      edge_d[EDGE_L]  = ~c_first_q & abs_gt(c_q, l_q, i_th);
      edge_d[EDGE_R]  = v & abs_gt(c_q, i_pix, i_th);
      edge_d[EDGE_U]  = up_ok & abs_gt(c_q, up_rd, i_th);
      edge_d[EDGE_UL] = up_ok & ~c_first_q & abs_gt(c_q, ul, i_th);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt_q    <= '0;
         c_q        <= '0;
         l_q        <= '0;
         ul_q       <= '0;
         c_vld_q    <= 1'b0;
         c_first_q  <= 1'b0;
         c_big_q    <= 1'b0;
         row_seen_q <= 1'b0;
         hs_q       <= '0;
         vs_q       <= '0;
         en_q       <= 1'b0;
         prev_q     <= '0;
         curr_q     <= '0;
         edge_q     <= '0;
      end else begin
         hs_q <= {hs_q[0], i_hs};
         vs_q <= {vs_q[0], i_vs};
         en_q <= emit;
         if (emit) begin
            prev_q <= l_q;
            curr_q <= c_q;
            edge_q <= edge_d;
         end

         if (v) begin
            c_q       <= i_pix;
            l_q       <= c_vld_q ? c_q : i_pix;
            c_first_q <= (x_cnt_q == '0);
            c_big_q   <= ~in_rng;
            c_vld_q   <= 1'b1;
            if (c_vld_q) ul_q <= up_rd;
            if (in_rng) x_cnt_q <= x_cnt_q + CW'(1);
         end else begin
            c_vld_q <= 1'b0;
            x_cnt_q <= '0;
         end

         if (!i_vs)
            row_seen_q <= 1'b0;
         else if (!v && c_vld_q)
            row_seen_q <= 1'b1;
      end
   end

   assign o_hs      = hs_q[1];
   assign o_vs      = vs_q[1];
   assign o_en      = en_q;
   assign o_prev    = prev_q;
   assign o_curr    = curr_q;
   assign o_is_edge = edge_q;

endmodule
